// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
// The sweep FSM state type lives here so the top and any checkers agree on it.
package regfile_pkg;

    localparam int DEFAULT_DW   = 10;
    localparam int DEFAULT_NREG = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, zero-R0 masking, write bypass and output mux.
// Q and its busy flag update together on the falling clock edge.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int  DW      = DEFAULT_DW,
    parameter int  NREG    = DEFAULT_NREG,
    parameter bit  BYPASS  = 1'b1,
    parameter bit  ZERO_R0 = 1'b0,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [AW-1:0]             addr,
    input  logic [NREG-1:0][DW-1:0]   regs,
    input  logic [NREG-1:0]           busy,
    input  logic                      wr_ok,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DW-1:0]             wr_data,
    output logic [DW-1:0]             q,
    output logic                      q_busy
);

    localparam logic [AW:0] LIMIT = (AW+1)'(NREG);

    logic [DW-1:0] sel_data;
    logic          sel_busy;
    logic          in_range;
    logic          zero_hit;
    logic          fwd;
    logic [DW-1:0] q_next;
    logic          busy_next;

    // Loop mux keeps addresses beyond NREG from indexing past the array.
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                sel_data = regs[i];
                sel_busy = busy[i];
            end
        end
    end

    assign in_range = ({1'b0, addr} < LIMIT);
    assign zero_hit = ZERO_R0 && (addr == '0);
    assign fwd      = BYPASS && wr_ok && (wr_addr == addr);

    always_comb begin
        q_next    = '0;
        busy_next = 1'b0;
        if (en && in_range && !zero_hit) begin
            if (fwd) begin
                q_next = wr_data;
            end else begin
                q_next    = sel_data;
                busy_next = sel_busy;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            q      <= '0;
            q_busy <= 1'b0;
        end else begin
            q      <= q_next;
            q_busy <= busy_next;
        end
    end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file with busy scoreboard, optional bypass / zero-R0 and a soft-clear sweep.
// All state changes on the falling edge of CLKb; RST is synchronous and overrides everything.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int  DW      = DEFAULT_DW,
    parameter int  NREG    = DEFAULT_NREG,
    parameter bit  BYPASS  = 1'b1,
    parameter bit  ZERO_R0 = 1'b0,
    localparam int AW      = $clog2(NREG)
) (
    input  logic          CLKb,
    input  logic          RST,
    input  logic [DW-1:0] D,
    input  logic          ENW,
    input  logic [AW-1:0] WRA,
    input  logic          ENR0,
    input  logic [AW-1:0] RDA0,
    input  logic          ENR1,
    input  logic [AW-1:0] RDA1,
    input  logic          RSV,
    input  logic [AW-1:0] RSA,
    input  logic          CLR,
    output logic [DW-1:0] Q0,
    output logic [DW-1:0] Q1,
    output logic          BUSY0,
    output logic          BUSY1,
    output logic          CLRBUSY
);

    localparam logic [AW:0]   LIMIT    = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0]         busy;

    sweep_state_t  state;
    sweep_state_t  state_next;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic          sweep_on;

    logic            wr_ok;
    logic            rsv_ok;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] rsv_hit;
    logic [NREG-1:0] sweep_hit;

    assign wr_ok  = ENW && ({1'b0, WRA} < LIMIT) && !(ZERO_R0 && (WRA == '0));
    assign rsv_ok = RSV && ({1'b0, RSA} < LIMIT) && !(ZERO_R0 && (RSA == '0));

    always_comb begin
        wr_hit    = '0;
        rsv_hit   = '0;
        sweep_hit = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_hit[i]    = wr_ok && (WRA == AW'(i));
            rsv_hit[i]   = rsv_ok && (RSA == AW'(i));
            sweep_hit[i] = sweep_on && (idx == AW'(i));
        end
    end

    // Sweep walks idx 0..NREG-1, one entry per edge; CLR during a sweep is ignored.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        sweep_on   = 1'b0;
        case (state)
            IDLE: begin
                if (CLR) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                sweep_on = 1'b1;
                idx_next = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Priority per entry: sweep clear, then write, then reserve (reserve always leaves busy set).
    always_ff @(negedge CLKb) begin
        if (RST) begin
            regs  <= '0;
            busy  <= '0;
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            for (int i = 0; i < NREG; i++) begin
                if (sweep_hit[i]) begin
                    regs[i] <= '0;
                    busy[i] <= 1'b0;
                end
                if (wr_hit[i]) begin
                    regs[i] <= D;
                    busy[i] <= 1'b0;
                end
                if (rsv_hit[i]) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    assign CLRBUSY = (state == SWEEP);

    regfile_read_port #(
        .DW      (DW),
        .NREG    (NREG),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_port0 (
        .clk     (CLKb),
        .rst     (RST),
        .en      (ENR0),
        .addr    (RDA0),
        .regs    (regs),
        .busy    (busy),
        .wr_ok   (wr_ok),
        .wr_addr (WRA),
        .wr_data (D),
        .q       (Q0),
        .q_busy  (BUSY0)
    );

    regfile_read_port #(
        .DW      (DW),
        .NREG    (NREG),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_port1 (
        .clk     (CLKb),
        .rst     (RST),
        .en      (ENR1),
        .addr    (RDA1),
        .regs    (regs),
        .busy    (busy),
        .wr_ok   (wr_ok),
        .wr_addr (WRA),
        .wr_data (D),
        .q       (Q1),
        .q_busy  (BUSY1)
    );

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the 4x10 register file; same negedge-clocked, enable-gated, registered-read style.
- Generalised in register count and data width.
- Adds:
  - optional write-to-read bypass
  - optional hardwired-zero R0
  - a per-register busy scoreboard for in-flight results
  - a multi-cycle soft-clear sweep
- Sits between datapath writeback and operand fetch.

Parameters:
- DW, 10, data width in bits.
- NREG, 4, number of registers (>=2, need not be a power of two).
- AW, $clog2(NREG), address width (derived, not overridden).
- BYPASS, 1, 1 = same-edge write data forwarded to a matching read.
- ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes.

Ports:
- CLKb  input  1  clock; all state updates on its falling edge.
- RST  input  1  synchronous active-high reset, sampled on falling edge of CLKb.
- D  input  DW  write data.
- ENW  input  1  write enable.
- WRA  input  AW  write address.
- ENR0  input  1  read port 0 enable.
- RDA0  input  AW  read port 0 address.
- ENR1  input  1  read port 1 enable.
- RDA1  input  AW  read port 1 address.
- RSV  input  1  reserve enable; marks a register busy.
- RSA  input  AW  reserve address.
- CLR  input  1  start soft-clear sweep (single-cycle request).
- Q0  output  DW  read port 0 data, registered.
- Q1  output  DW  read port 1 data, registered.
- BUSY0  output  1  registered busy flag accompanying Q0.
- BUSY1  output  1  registered busy flag accompanying Q1.
- CLRBUSY  output  1  high while sweep in progress.

Behaviour:
- Clock and reset:
  - One clock, CLKb; reset is synchronous and active-high; every register updates on the falling edge of CLKb only.
  - RST high at an edge: all array entries, Q0, Q1, BUSY0, BUSY1 and busy bits go to 0; FSM to IDLE (CLRBUSY=0).
  - RST overrides all other inputs that edge.
- Write:
  - ENW=1 at an edge writes D to reg[WRA].
  - The write is ignored when WRA>=NREG, or when ZERO_R0=1 and WRA=0.
  - A performed write clears busy[WRA].
- Read (per port n):
  - Latency is one edge.
  - ENRn=0: Qn<=0, BUSYn<=0.
  - ENRn=1 and RDAn>=NREG: Qn<=0, BUSYn<=0.
  - Otherwise, when BYPASS=1 and a performed write targets RDAn at the same edge: Qn<=D, BUSYn<=0.
  - In all other cases: Qn<=reg[RDAn] (pre-edge value), BUSYn<=busy[RDAn] (pre-edge value).
  - ZERO_R0=1 and RDAn=0: Qn<=0, BUSYn<=0.
  - Both ports may read the same address.
- Scoreboard:
  - RSV=1 with valid RSA sets busy[RSA]; invalid RSA is ignored.
  - Same-edge RSV and performed write to the same address: busy ends at 1 (reserve wins); data is still written.
  - RSV to R0 with ZERO_R0=1 is ignored.
- Sweep FSM, states IDLE and SWEEP, index register idx (AW bits):
  - IDLE: CLR=1 -> SWEEP, idx<=0.
  - SWEEP: each edge clears reg[idx] and busy[idx], then idx<=idx+1. After the edge clearing idx=NREG-1, go to IDLE.
  - CLRBUSY = (state==SWEEP), decoded from the state register. It is high for exactly NREG cycles after the edge that samples CLR.
  - CLR while in SWEEP is ignored (no restart).
  - Performed write to the same address as the sweep clear at that edge: the write wins, reg takes D and busy is cleared.
  - RSV to the same address as the sweep clear at that edge: busy ends at 1.
  - Reads during SWEEP return the current array contents; entries not yet reached keep their old values.
  - RST mid-sweep: immediate full clear, IDLE.

Decomposition:
- Package regfile_pkg:
  - sweep_state_t enum {IDLE, SWEEP}
  - default DW/NREG localparams
- Sub-module regfile_read_port, instantiated twice. It holds the Qn/BUSYn output registers and contains:
  - address range check
  - zero-R0 check
  - bypass compare
  - output mux
- Top level holds the array, busy vector, write decode and sweep FSM.

Test Plan:
- Reset then read: RST=1 one edge; ENR0=1, RDA0=2 -> Q0=0, BUSY0=0. Defaults DW=10, NREG=4.
- Write/read latency: ENW, WRA=1, D=10'h2A5. Next edge ENR0=1, RDA0=1 -> Q0=10'h2A5 one edge later. ENR1=0 -> Q1=0.
- Bypass: reg3=10'h011; same edge ENW, WRA=3, D=10'h3FF and ENR0, RDA0=3. BYPASS=1 -> Q0=10'h3FF. BYPASS=0 -> Q0=10'h011, and 10'h3FF on the next read.
- Scoreboard: RSV, RSA=2 -> read R2 gives BUSY0=1. Write R2=10'h055 -> following read gives Q0=10'h055, BUSY0=0. Same-edge RSV+ENW to R2 -> BUSY0=1 afterwards.
- Sweep: all regs=10'h1FF, CLR pulse -> CLRBUSY high exactly 4 cycles. ENW R2=10'h123 during the sweep edge clearing R2 -> final R0=R1=R3=0, R2=10'h123. CLR again mid-sweep -> no extension.
- Boundaries: NREG=5, ZERO_R0=1. Write WRA=0 or WRA=6 -> ignored. Read RDA0=0 or 7 -> Q0=0. RST on 2nd sweep cycle -> all regs 0, CLRBUSY=0 next cycle.
